// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types and constants: register index/word types,
// mux select encodings, and the condition-code encoding.
package lc3_pkg;

    typedef logic [2:0]  reg_idx_t;
    typedef logic [15:0] word_t;

    localparam int       NUM_REGS = 8;
    localparam reg_idx_t R7       = 3'b111;

    localparam logic DR_IR119  = 1'b0;
    localparam logic DR_R7     = 1'b1;
    localparam logic SR1_IR119 = 1'b0;
    localparam logic SR1_IR86  = 1'b1;

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

    // Sign bit wins over zero test, so exactly one flag is ever produced.
    function automatic logic [2:0] cc_of(input word_t w);
        if (w[15])
            return CC_N;
        else if (w == 16'h0000)
            return CC_Z;
        else
            return CC_P;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Eight 16-bit general registers: two combinational read ports, one
// synchronous write port, synchronous clear of every register.
module reg_file
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [2:0]  raddr_a,
    input  logic [2:0]  raddr_b,
    output logic [15:0] rdata_a,
    output logic [15:0] rdata_b
);

    logic [NUM_REGS-1:0]       wsel;
    logic [NUM_REGS-1:0][15:0] regs;

    assign wsel = we ? (NUM_REGS'(1) << waddr) : '0;

    // Registers live in flops rather than RAM since all of them clear on reset.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [15:0] q_reg;

            always_ff @(posedge clk) begin
                if (srst)
                    q_reg <= '0;
                else if (wsel[gi])
                    q_reg <= wdata;
            end

            assign regs[gi] = q_reg;
        end
    endgenerate

    // No bypass: a same-cycle write is seen only after the edge.
    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/reg_file_cc.sv
// LC-3 register file wrapper: DR/SR1 select muxes, NZP condition codes
// derived from the bus, and the branch-enable register.
module reg_file_cc
    import lc3_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_ah,
    input  logic [15:0] Bus,
    input  logic [15:0] IR,
    input  logic        LD_REG,
    input  logic        LD_CC,
    input  logic        LD_BEN,
    input  logic        DRMUX,
    input  logic        SR1MUX,
    output logic [15:0] SR1_out,
    output logic [15:0] SR2_out,
    output logic [2:0]  NZP,
    output logic        BEN
);

    reg_idx_t   dr;
    reg_idx_t   sr1;
    logic [2:0] nzp_reg;
    logic       ben_reg;
    logic       ir_unused;

    assign dr  = (DRMUX  == DR_IR119)  ? IR[11:9] : R7;
    assign sr1 = (SR1MUX == SR1_IR119) ? IR[11:9] : IR[8:6];

    assign ir_unused = ^{IR[15:12], IR[5:3]};

    reg_file u_reg_file (
        .clk     (Clk),
        .srst    (Reset_ah),
        .we      (LD_REG),
        .waddr   (dr),
        .wdata   (Bus),
        .raddr_a (sr1),
        .raddr_b (IR[2:0]),
        .rdata_a (SR1_out),
        .rdata_b (SR2_out)
    );

    // BEN samples nzp_reg before this edge's CC load lands.
    always_ff @(posedge Clk) begin
        if (Reset_ah) begin
            nzp_reg <= CC_Z;
            ben_reg <= 1'b0;
        end else begin
            if (LD_CC)
                nzp_reg <= cc_of(Bus);
            if (LD_BEN)
                ben_reg <= |(IR[11:9] & nzp_reg);
        end
    end

    assign NZP = nzp_reg;
    assign BEN = ben_reg;

endmodule

// File: tb/tb_reg_file_cc.sv
// Directed table-driven bench for reg_file_cc plus hand sequences for
// reset clearing and the no-bypass read timing.
module tb_reg_file_cc;

    logic        Clk = 1'b0;
    logic        Reset_ah = 1'b0;
    logic [15:0] Bus = '0;
    logic [15:0] IR = '0;
    logic        LD_REG = 1'b0;
    logic        LD_CC = 1'b0;
    logic        LD_BEN = 1'b0;
    logic        DRMUX = 1'b0;
    logic        SR1MUX = 1'b0;
    logic [15:0] SR1_out;
    logic [15:0] SR2_out;
    logic [2:0]  NZP;
    logic        BEN;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    reg_file_cc dut (
        .Clk      (Clk),
        .Reset_ah (Reset_ah),
        .Bus      (Bus),
        .IR       (IR),
        .LD_REG   (LD_REG),
        .LD_CC    (LD_CC),
        .LD_BEN   (LD_BEN),
        .DRMUX    (DRMUX),
        .SR1MUX   (SR1MUX),
        .SR1_out  (SR1_out),
        .SR2_out  (SR2_out),
        .NZP      (NZP),
        .BEN      (BEN)
    );

    typedef struct {
        logic        rst;
        logic [15:0] bus;
        logic [15:0] ir;
        logic        ld_reg;
        logic        ld_cc;
        logic        ld_ben;
        logic        drmux;
        logic        sr1mux;
        logic [15:0] e_sr1;
        logic [15:0] e_sr2;
        logic [2:0]  e_nzp;
        logic        e_ben;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] ir_of(input logic [2:0] a, input logic [2:0] b,
                                          input logic [2:0] c);
        return {4'b0000, a, b, 3'b000, c};
    endfunction

    function automatic vec_t mk(input logic rst, input logic [15:0] bus, input logic [15:0] ir,
                                input logic ld_reg, input logic ld_cc, input logic ld_ben,
                                input logic drmux, input logic sr1mux,
                                input logic [15:0] e_sr1, input logic [15:0] e_sr2,
                                input logic [2:0] e_nzp, input logic e_ben);
        vec_t v;
        v.rst = rst; v.bus = bus; v.ir = ir;
        v.ld_reg = ld_reg; v.ld_cc = ld_cc; v.ld_ben = ld_ben;
        v.drmux = drmux; v.sr1mux = sr1mux;
        v.e_sr1 = e_sr1; v.e_sr2 = e_sr2; v.e_nzp = e_nzp; v.e_ben = e_ben;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        Reset_ah = v.rst; Bus = v.bus; IR = v.ir;
        LD_REG = v.ld_reg; LD_CC = v.ld_cc; LD_BEN = v.ld_ben;
        DRMUX = v.drmux; SR1MUX = v.sr1mux;
    endtask

    logic [15:0] wd [8];

    initial begin
        wd[0] = 16'h0A0A; wd[1] = 16'h1111; wd[2] = 16'h2222; wd[3] = 16'h1234;
        wd[4] = 16'h4444; wd[5] = 16'h5555; wd[6] = 16'h6666; wd[7] = 16'h7777;

        // rst bus ir ld_reg ld_cc ld_ben drmux sr1mux | sr1 sr2 nzp ben
        vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 3'b010, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, wd[i], ir_of(3'(i), 3'd0, 3'(i)), 1, 0, 0, 0, 0,
                              wd[i], wd[i], 3'b010, 0));
        vecs.push_back(mk(0, 16'h0000, ir_of(3'd0, 3'd5, 3'd1), 0, 0, 0, 0, 1,
                          16'h5555, 16'h1111, 3'b010, 0));
        vecs.push_back(mk(0, 16'h3001, ir_of(3'd2, 3'd0, 3'd7), 1, 0, 0, 1, 0,
                          16'h2222, 16'h3001, 3'b010, 0));
        vecs.push_back(mk(0, 16'h8000, 16'h0000, 0, 1, 0, 0, 0, 16'h0A0A, 16'h0A0A, 3'b100, 0));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 16'h0A0A, 16'h0A0A, 3'b010, 0));
        vecs.push_back(mk(0, 16'h7FFF, 16'h0000, 0, 1, 0, 0, 0, 16'h0A0A, 16'h0A0A, 3'b001, 0));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 16'h0A0A, 16'h0A0A, 3'b010, 0));
        vecs.push_back(mk(0, 16'hFFFF, ir_of(3'd2, 3'd0, 3'd0), 0, 1, 1, 0, 0,
                          16'h2222, 16'h0A0A, 3'b100, 1));
        vecs.push_back(mk(0, 16'hFFFF, ir_of(3'd2, 3'd0, 3'd0), 0, 0, 1, 0, 0,
                          16'h2222, 16'h0A0A, 3'b100, 0));
        vecs.push_back(mk(0, 16'h0000, ir_of(3'd4, 3'd0, 3'd0), 0, 0, 1, 0, 0,
                          16'h4444, 16'h0A0A, 3'b100, 1));
        vecs.push_back(mk(1, 16'hFFFF, ir_of(3'd7, 3'd0, 3'd7), 1, 1, 1, 0, 0,
                          16'h0000, 16'h0000, 3'b010, 0));

        foreach (vecs[k]) begin
            @(negedge Clk);
            drive(vecs[k]);
            @(posedge Clk);
            #1;
            $display("vec %0d: ir=%h bus=%h sr1=%h sr2=%h nzp=%b ben=%b",
                     k, IR, Bus, SR1_out, SR2_out, NZP, BEN);
            check($sformatf("vec%0d sr1", k), SR1_out, vecs[k].e_sr1);
            check($sformatf("vec%0d sr2", k), SR2_out, vecs[k].e_sr2);
            check($sformatf("vec%0d nzp", k), 16'(NZP), 16'(vecs[k].e_nzp));
            check($sformatf("vec%0d ben", k), 16'(BEN), 16'(vecs[k].e_ben));
        end

        // Every register reads zero after the reset that overrode the loads.
        @(negedge Clk);
        Reset_ah = 0; LD_REG = 0; LD_CC = 0; LD_BEN = 0; DRMUX = 0; SR1MUX = 1;
        for (int i = 0; i < 8; i++) begin
            IR = ir_of(3'd0, 3'(i), 3'(i));
            #1;
            $display("clear R%0d: sr1=%h sr2=%h", i, SR1_out, SR2_out);
            check($sformatf("clear R%0d sr1", i), SR1_out, 16'h0000);
            check($sformatf("clear R%0d sr2", i), SR2_out, 16'h0000);
        end

        // Write to R3: old value before the edge, new value after it.
        @(negedge Clk);
        SR1MUX = 0; IR = ir_of(3'd3, 3'd0, 3'd3); Bus = 16'hABCD; LD_REG = 1;
        #1;
        $display("R3 pre-edge: sr1=%h sr2=%h", SR1_out, SR2_out);
        check("r3 pre-edge sr1", SR1_out, 16'h0000);
        check("r3 pre-edge sr2", SR2_out, 16'h0000);
        @(posedge Clk);
        #1;
        $display("R3 post-edge: sr1=%h sr2=%h", SR1_out, SR2_out);
        check("r3 post-edge sr1", SR1_out, 16'hABCD);
        check("r3 post-edge sr2", SR2_out, 16'hABCD);
        @(negedge Clk);
        LD_REG = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
